// File: rtl/ascon_job_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ascon_job_arbiter_if                                                     |
// | Client request/return lanes and shared ASCON core port bundle.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ascon_job_arbiter_if;
    logic         req0, req1;
    logic [1:0]   mode0, mode1;
    logic [127:0] key0, key1;
    logic [127:0] nonce0, nonce1;
    logic [3:0]   datalen0, datalen1;
    logic [63:0]  blockin0, blockin1;
    logic         gnt0, gnt1;
    logic         read0, read1;
    logic         ctv0, ctv1;
    logic         tv0, tv1;
    logic         err0, err1;
    logic         core_start;
    logic [1:0]   core_mode;
    logic [127:0] core_key, core_nonce;
    logic [3:0]   core_datalen;
    logic [63:0]  core_blockin;
    logic         core_read, core_ctv, core_tv;
    logic         core_rst_n;

    modport slave (
        input  req0, req1, mode0, mode1, key0, key1, nonce0, nonce1,
               datalen0, datalen1, blockin0, blockin1,
               core_read, core_ctv, core_tv,
        output gnt0, gnt1, read0, read1, ctv0, ctv1, tv0, tv1, err0, err1,
               core_start, core_mode, core_key, core_nonce,
               core_datalen, core_blockin, core_rst_n
    );

    modport master (
        output req0, req1, mode0, mode1, key0, key1, nonce0, nonce1,
               datalen0, datalen1, blockin0, blockin1,
               core_read, core_ctv, core_tv,
        input  gnt0, gnt1, read0, read1, ctv0, ctv1, tv0, tv1, err0, err1,
               core_start, core_mode, core_key, core_nonce,
               core_datalen, core_blockin, core_rst_n
    );
endinterface
`default_nettype wire

// File: rtl/ascon_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ascon_job_arbiter                                                        |
// | Round-robin sharing of one ASCON core between two requesters.            |
// | Optional busy watchdog: define ASCON_ARB_WATCHDOG_EN.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ascon_job_arbiter
`ifdef ASCON_ARB_WATCHDOG_EN
#(
    parameter int unsigned TIMEOUT = 64
)
`endif
(
    input  logic                clk,
    input  logic                nRST,
    ascon_job_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_last;
    logic [1:0]   r_mode;
    logic [127:0] r_key;
    logic [127:0] r_nonce;
    logic         w_any_req;
    logic         w_win;
    logic         w_take;
    logic         w_owned;
    logic         w_busy;
    logic         w_timeout;

    // r_last is updated to the winner at grant, so it names the owner afterwards
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
        w_take    = (r_state == S_IDLE) & w_any_req;
        w_owned   = (r_state == S_GRANT) | (r_state == S_BUSY);
        w_busy    = (r_state == S_BUSY);
    end

`ifdef ASCON_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (w_take) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A completing tag in the expiry cycle takes priority over the abort
    assign w_timeout = w_busy & (r_cnt == CNT_W'(TIMEOUT - 1)) & ~bus.core_tv;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_GRANT;
            S_GRANT: w_next = S_BUSY;
            S_BUSY:  if (bus.core_tv || w_timeout) w_next = S_DRAIN;
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_last  <= 1'b1;
            r_mode  <= '0;
            r_key   <= '0;
            r_nonce <= '0;
        end else if (w_take) begin
            r_last  <= w_win;
            r_mode  <= w_win ? bus.mode1  : bus.mode0;
            r_key   <= w_win ? bus.key1   : bus.key0;
            r_nonce <= w_win ? bus.nonce1 : bus.nonce0;
        end
    end

    // Return strobes are routed only while the core is actually running a job
    always_comb begin
        bus.gnt0         = w_owned & ~r_last;
        bus.gnt1         = w_owned &  r_last;
        bus.read0        = w_busy & ~r_last & bus.core_read;
        bus.read1        = w_busy &  r_last & bus.core_read;
        bus.ctv0         = w_busy & ~r_last & bus.core_ctv;
        bus.ctv1         = w_busy &  r_last & bus.core_ctv;
        bus.tv0          = w_busy & ~r_last & bus.core_tv;
        bus.tv1          = w_busy &  r_last & bus.core_tv;
        bus.err0         = w_timeout & ~r_last;
        bus.err1         = w_timeout &  r_last;
        bus.core_rst_n   = ~w_timeout;
        bus.core_start   = (r_state == S_GRANT);
        bus.core_mode    = r_mode;
        bus.core_key     = r_key;
        bus.core_nonce   = r_nonce;
        bus.core_datalen = '0;
        bus.core_blockin = '0;
        if (w_owned) begin
            bus.core_datalen = r_last ? bus.datalen1 : bus.datalen0;
            bus.core_blockin = r_last ? bus.blockin1 : bus.blockin0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_job_arbiter.sv
`default_nettype none
// Self-checking bench for ascon_job_arbiter: randomized jobs against a
// round-robin reference model of ownership, latching and strobe routing.
module tb_ascon_job_arbiter;
    logic clk = 1'b0;
    logic nRST;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_last;

    always #5 clk = ~clk;

    ascon_job_arbiter_if bus_if ();

`ifdef ASCON_ARB_WATCHDOG_EN
    ascon_job_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .nRST(nRST), .bus(bus_if));
`else
    ascon_job_arbiter dut (.clk(clk), .nRST(nRST), .bus(bus_if));
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.req0 = 0; bus_if.req1 = 0; bus_if.mode0 = 0; bus_if.mode1 = 0;
        bus_if.key0 = 0; bus_if.key1 = 0; bus_if.nonce0 = 0; bus_if.nonce1 = 0;
        bus_if.datalen0 = 0; bus_if.datalen1 = 0; bus_if.blockin0 = 0; bus_if.blockin1 = 0;
        bus_if.core_read = 0; bus_if.core_ctv = 0; bus_if.core_tv = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        nRST = 0;
        cyc();
        nRST = 1;
        m_last = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        nRST = 0;
        cyc();
        cyc();
        bus_if.core_read = 1; bus_if.core_ctv = 1; bus_if.core_tv = 1;
        #1;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.gnt1, bus_if.core_start, bus_if.err0, bus_if.err1, bus_if.core_rst_n} !== 6'b000001) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 000001", {bus_if.gnt0, bus_if.gnt1, bus_if.core_start, bus_if.err0, bus_if.err1, bus_if.core_rst_n});
        end
        n_cmp++;
        if ({bus_if.core_mode, bus_if.core_key, bus_if.core_nonce, bus_if.core_datalen, bus_if.core_blockin} !== '0) begin
            n_bad++;
            $display("FAIL reset_params: got mode %h key %h nonce %h required zeros", bus_if.core_mode, bus_if.core_key, bus_if.core_nonce);
        end
        n_cmp++;
        if ({bus_if.read0, bus_if.read1, bus_if.ctv0, bus_if.ctv1, bus_if.tv0, bus_if.tv1} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b required 000000", {bus_if.read0, bus_if.read1, bus_if.ctv0, bus_if.ctv1, bus_if.tv0, bus_if.tv1});
        end
        drive_idle();
        nRST = 1;
        m_last = 1'b1;
    endtask

    task automatic test_single_req0();
        logic [127:0] k;
        k = 128'h000102030405060708090A0B0C0D0E0F;
        bus_if.req0 = 1; bus_if.mode0 = 2'd0; bus_if.key0 = k;
        cyc();
        m_last = 1'b0;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.gnt1, bus_if.core_start} !== 3'b101 || bus_if.core_key !== k || bus_if.core_mode !== 2'd0) begin
            n_bad++;
            $display("FAIL single_grant: got gnt0/gnt1/start %b key %h required 101 key %h",
                     {bus_if.gnt0, bus_if.gnt1, bus_if.core_start}, bus_if.core_key, k);
        end
        cyc();
        bus_if.core_tv = 1;
        #1;
        n_cmp++;
        if ({bus_if.tv0, bus_if.tv1, bus_if.gnt0, bus_if.core_start} !== 4'b1010) begin
            n_bad++;
            $display("FAIL single_tv: got tv0/tv1/gnt0/start %b required 1010", {bus_if.tv0, bus_if.tv1, bus_if.gnt0, bus_if.core_start});
        end
        cyc();
        bus_if.core_tv = 0; bus_if.req0 = 0;
        #1;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.gnt1, bus_if.tv0} !== 3'b000) begin
            n_bad++;
            $display("FAIL single_drain: got gnt0/gnt1/tv0 %b required 000", {bus_if.gnt0, bus_if.gnt1, bus_if.tv0});
        end
        cyc();
    endtask

    // Starts in an IDLE cycle, returns in the following IDLE cycle with requests low
    task automatic run_job(input bit r0, input bit r1, input int busy_len);
        bit           w;
        logic [1:0]   e_mode;
        logic [127:0] e_key, e_nonce;
        logic [5:0]   e_route;
        logic [67:0]  e_data;
        bus_if.req0 = r0; bus_if.req1 = r1;
        bus_if.mode0 = 2'($urandom_range(0, 3)); bus_if.mode1 = 2'($urandom_range(0, 3));
        bus_if.key0 = {$urandom, $urandom, $urandom, $urandom};
        bus_if.key1 = {$urandom, $urandom, $urandom, $urandom};
        bus_if.nonce0 = {$urandom, $urandom, $urandom, $urandom};
        bus_if.nonce1 = {$urandom, $urandom, $urandom, $urandom};
        w       = (r0 && r1) ? !m_last : r1;
        m_last  = w;
        e_mode  = w ? bus_if.mode1  : bus_if.mode0;
        e_key   = w ? bus_if.key1   : bus_if.key0;
        e_nonce = w ? bus_if.nonce1 : bus_if.nonce0;
        cyc();
        n_cmp++;
        if ({bus_if.gnt1, bus_if.gnt0, bus_if.core_start} !== {w, !w, 1'b1}) begin
            n_bad++;
            $display("FAIL job_grant: got gnt1/gnt0/start %b required %b", {bus_if.gnt1, bus_if.gnt0, bus_if.core_start}, {w, !w, 1'b1});
        end
        n_cmp++;
        if (bus_if.core_mode !== e_mode || bus_if.core_key !== e_key || bus_if.core_nonce !== e_nonce) begin
            n_bad++;
            $display("FAIL job_latch: got mode %h key %h required mode %h key %h", bus_if.core_mode, bus_if.core_key, e_mode, e_key);
        end
        for (int i = 0; i < busy_len; i++) begin
            cyc();
            bus_if.req0 = 1'($urandom_range(0, 1)); bus_if.req1 = 1'($urandom_range(0, 1));
            bus_if.mode0 = 2'($urandom_range(0, 3)); bus_if.mode1 = 2'($urandom_range(0, 3));
            bus_if.key0 = {$urandom, $urandom, $urandom, $urandom};
            bus_if.key1 = {$urandom, $urandom, $urandom, $urandom};
            bus_if.nonce1 = {$urandom, $urandom, $urandom, $urandom};
            bus_if.datalen0 = 4'($urandom_range(0, 8)); bus_if.datalen1 = 4'($urandom_range(0, 8));
            bus_if.blockin0 = {$urandom, $urandom}; bus_if.blockin1 = {$urandom, $urandom};
            bus_if.core_read = 1'($urandom_range(0, 1)); bus_if.core_ctv = 1'($urandom_range(0, 1));
            bus_if.core_tv = (i == busy_len - 1);
            #1;
            e_route = {w & bus_if.core_read, !w & bus_if.core_read, w & bus_if.core_ctv,
                       !w & bus_if.core_ctv, w & bus_if.core_tv, !w & bus_if.core_tv};
            e_data  = w ? {bus_if.datalen1, bus_if.blockin1} : {bus_if.datalen0, bus_if.blockin0};
            n_cmp++;
            if ({bus_if.gnt1, bus_if.gnt0, bus_if.core_start, bus_if.err1, bus_if.err0, bus_if.core_rst_n} !== {w, !w, 4'b0001}) begin
                n_bad++;
                $display("FAIL busy_ctrl: got %b required %b", {bus_if.gnt1, bus_if.gnt0, bus_if.core_start, bus_if.err1, bus_if.err0, bus_if.core_rst_n}, {w, !w, 4'b0001});
            end
            n_cmp++;
            if (bus_if.core_mode !== e_mode || bus_if.core_key !== e_key || bus_if.core_nonce !== e_nonce) begin
                n_bad++;
                $display("FAIL busy_stable: got mode %h key %h required mode %h key %h", bus_if.core_mode, bus_if.core_key, e_mode, e_key);
            end
            n_cmp++;
            if ({bus_if.read1, bus_if.read0, bus_if.ctv1, bus_if.ctv0, bus_if.tv1, bus_if.tv0} !== e_route) begin
                n_bad++;
                $display("FAIL busy_route: got %b required %b", {bus_if.read1, bus_if.read0, bus_if.ctv1, bus_if.ctv0, bus_if.tv1, bus_if.tv0}, e_route);
            end
            n_cmp++;
            if ({bus_if.core_datalen, bus_if.core_blockin} !== e_data) begin
                n_bad++;
                $display("FAIL busy_data: got %h required %h", {bus_if.core_datalen, bus_if.core_blockin}, e_data);
            end
        end
        cyc();
        bus_if.core_tv = 0; bus_if.core_read = 1; bus_if.core_ctv = 1;
        bus_if.req0 = 1'($urandom_range(0, 1)); bus_if.req1 = 1'($urandom_range(0, 1));
        #1;
        n_cmp++;
        if ({bus_if.gnt1, bus_if.gnt0, bus_if.core_start, bus_if.read0, bus_if.read1} !== 5'b0 ||
            {bus_if.core_datalen, bus_if.core_blockin} !== 68'd0 || bus_if.core_key !== e_key) begin
            n_bad++;
            $display("FAIL job_drain: got gnt1/gnt0/start/rd %b datalen %h key %h required 00000 0 %h",
                     {bus_if.gnt1, bus_if.gnt0, bus_if.core_start, bus_if.read0, bus_if.read1}, bus_if.core_datalen, bus_if.core_key, e_key);
        end
        cyc();
        bus_if.req0 = 0; bus_if.req1 = 0; bus_if.core_read = 0; bus_if.core_ctv = 0;
        #1;
        n_cmp++;
        if ({bus_if.gnt1, bus_if.gnt0, bus_if.core_start} !== 3'b000) begin
            n_bad++;
            $display("FAIL job_idle: got gnt1/gnt0/start %b required 000", {bus_if.gnt1, bus_if.gnt0, bus_if.core_start});
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        // Both requesters held for three jobs in a row: req0, req1, req0
        for (int j = 0; j < 3; j++) run_job(1'b1, 1'b1, 2);
        n_cmp++;
        if (m_last !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_sequence: model owner after third job %0d required 0", m_last);
        end
    endtask

    task automatic test_random_jobs();
        bit r0, r1;
        for (int j = 0; j < 20; j++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_job(r0, r1, $urandom_range(1, 5));
        end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        run_job(1'b1, 1'b1, 1);
        bus_if.req0 = 1; bus_if.req1 = 1;
        cyc();
        cyc();
        bus_if.core_read = 1;
        #1;
        n_cmp++;
        if ({bus_if.gnt1, bus_if.read1, bus_if.read0} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_busy_owner: got gnt1/read1/read0 %b required 110", {bus_if.gnt1, bus_if.read1, bus_if.read0});
        end
        nRST = 0;
        cyc();
        nRST = 1;
        m_last = 1'b1;
        #1;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.gnt1, bus_if.core_start, bus_if.read0, bus_if.read1, bus_if.core_rst_n} !== 6'b000001 ||
            bus_if.core_key !== 128'd0 || bus_if.core_mode !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_busy_reset: got %b key %h required 000001 key 0",
                     {bus_if.gnt0, bus_if.gnt1, bus_if.core_start, bus_if.read0, bus_if.read1, bus_if.core_rst_n}, bus_if.core_key);
        end
        cyc();
        bus_if.core_read = 0; bus_if.core_tv = 1;
        #1;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.gnt1, bus_if.core_start, bus_if.tv0} !== 4'b1010) begin
            n_bad++;
            $display("FAIL post_reset_grant: got gnt0/gnt1/start/tv0 %b required 1010", {bus_if.gnt0, bus_if.gnt1, bus_if.core_start, bus_if.tv0});
        end
        m_last = 1'b0;
        cyc();
        #1;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.tv0} !== 2'b11) begin
            n_bad++;
            $display("FAIL tv_in_grant_ignored: got gnt0/tv0 %b required 11", {bus_if.gnt0, bus_if.tv0});
        end
        cyc();
        drive_idle();
        cyc();
    endtask

`ifdef ASCON_ARB_WATCHDOG_EN
    task automatic watchdog_job(input bit tv_at_limit);
        bus_if.req0 = 1;
        cyc();
        m_last = 1'b0;
        bus_if.req0 = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            bus_if.core_tv = tv_at_limit && (k == 8);
            #1;
            if (k < 8) begin
                n_cmp++;
                if ({bus_if.gnt0, bus_if.err0, bus_if.err1, bus_if.core_rst_n} !== 4'b1001) begin
                    n_bad++;
                    $display("FAIL wd_early: cycle %0d got gnt0/err0/err1/rst_n %b required 1001", k, {bus_if.gnt0, bus_if.err0, bus_if.err1, bus_if.core_rst_n});
                end
            end else begin
                n_cmp++;
                if ({bus_if.tv0, bus_if.err0, bus_if.err1, bus_if.core_rst_n} !== {tv_at_limit, !tv_at_limit, 1'b0, tv_at_limit}) begin
                    n_bad++;
                    $display("FAIL wd_limit: got tv0/err0/err1/rst_n %b required %b", {bus_if.tv0, bus_if.err0, bus_if.err1, bus_if.core_rst_n},
                             {tv_at_limit, !tv_at_limit, 1'b0, tv_at_limit});
                end
            end
        end
        cyc();
        bus_if.core_tv = 0;
        #1;
        n_cmp++;
        if ({bus_if.gnt0, bus_if.err0, bus_if.core_rst_n} !== 3'b001) begin
            n_bad++;
            $display("FAIL wd_drain: got gnt0/err0/rst_n %b required 001", {bus_if.gnt0, bus_if.err0, bus_if.core_rst_n});
        end
        cyc();
    endtask

    task automatic test_watchdog();
        watchdog_job(1'b0);
        run_job(1'b1, 1'b0, 1);
        watchdog_job(1'b1);
        run_job(1'b1, 1'b1, 2);
    endtask
`else
    task automatic test_no_watchdog();
        bit quiet;
        bus_if.req1 = 1;
        cyc();
        m_last = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 80; k++) begin
            cyc();
            bus_if.req1 = 0;
            #1;
            if ({bus_if.gnt1, bus_if.err0, bus_if.err1, bus_if.core_rst_n} !== 4'b1001) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL no_watchdog: owner lost or err/core_rst_n asserted during long busy, last %b required 1001",
                     {bus_if.gnt1, bus_if.err0, bus_if.err1, bus_if.core_rst_n});
        end
        bus_if.core_tv = 1;
        #1;
        n_cmp++;
        if ({bus_if.tv1, bus_if.tv0} !== 2'b10) begin
            n_bad++;
            $display("FAIL no_watchdog_tv: got tv1/tv0 %b required 10", {bus_if.tv1, bus_if.tv0});
        end
        cyc();
        bus_if.core_tv = 0;
        cyc();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation limit reached, required completion");
        $fatal(1);
    end

    initial begin
        m_last = 1'b1;
        test_reset();
        test_single_req0();
        test_round_robin();
        test_random_jobs();
        test_reset_mid_busy();
`ifdef ASCON_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
